rvfi_dmem_window_check: RTL and testbench
=========================================

Name: rvfi_dmem_window_check

Overview:
- Successor to the single-word data-memory consistency checker.
- Shadows a contiguous window of NWORDS aligned XLEN-bit words, starting at a base address, across NRET retire channels.
- Checks every retired load byte against the last retired store to that byte. Optionally handles misaligned accesses that span words, and checks retire-order continuity.
- Sits beside the core's RVFI port in the formal harness and in simulation benches. It reports a sticky error record as well as raising a formal assert.

Parameters:
- XLEN, 32, data/address width; byte lanes BL = XLEN/8.
- NRET, 1, number of retire channels.
- NWORDS, 4, shadowed words; power of two, 1..64.
- ALLOW_MISALIGNED, 0, 1 = byte i of an access is at mem_addr+i; 0 = mem_addr low log2(BL) bits must be zero.
- ORDER_CHECK, 1, 1 = enable the rvfi_order continuity check.
- ASSERT_EN, 1, 1 = emit a formal assert on any error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- dmem_base  in  XLEN  window base address; formal harness ties it to $anyconst; low log2(BL) bits are ignored.
- rvfi_valid  in  NRET  per-channel retire valid.
- rvfi_order  in  NRET*64  per-channel instruction index.
- rvfi_trap  in  NRET  trapped instruction; no memory effect.
- rvfi_mem_addr  in  NRET*XLEN  access address.
- rvfi_mem_rmask  in  NRET*BL  read byte mask.
- rvfi_mem_wmask  in  NRET*BL  write byte mask.
- rvfi_mem_rdata  in  NRET*XLEN  read data.
- rvfi_mem_wdata  in  NRET*XLEN  write data.
- err  out  1  sticky: an error has been recorded.
- err_code  out  2  0 none, 1 data mismatch, 2 misaligned, 3 order gap.
- err_order  out  64  rvfi_order of the offending channel.
- err_addr  out  XLEN  byte address of the first mismatching byte; otherwise the access address.
- read_checks  out  32  count of shadowed read bytes actually compared; saturates at all-ones.

Behaviour:
- Reset (async, active-high) clears:
  - err, err_code, err_order, err_addr, read_checks to 0;
  - all written bits;
  - the order tracker, which returns to the INIT state.
- Base capture:
  - base_q = dmem_base, aligned down, is loaded every cycle while reset is high.
  - base_q holds after reset deasserts.
  - Changes on dmem_base after that are ignored.
- Active channel: a channel participates when rvfi_valid=1 and rvfi_trap=0.
- Channel processing:
  - Processed in ascending channel index within a cycle.
  - A store on channel k is visible to a load on channel j>k in the same cycle.
  - This is combinational chaining of the shadow next-state; shadow registers update at the clock edge.
- Byte mapping:
  - Byte i of an access has address a = mem_addr + i, computed modulo 2^XLEN, so wrap-around at the top of the address space is legal.
  - The byte hits when (a - base_q) < NWORDS*BL. It then maps to word (a-base_q)/BL, lane (a-base_q)%BL.
  - With ALLOW_MISALIGNED=0, data lane i pairs with byte address mem_addr+i.
  - With ALLOW_MISALIGNED=1, bytes may straddle two window words, or the window edge; out-of-window bytes are ignored.
- Read check:
  - Applies when rmask[i]=1, the byte hits, and written=1 for that byte.
  - Compare rdata byte i against the shadow byte.
  - Each such compare increments read_checks by 1. Several per cycle may occur; add the sum and saturate.
  - Unwritten bytes are not checked.
- Write:
  - Applies when wmask[i]=1 and the byte hits.
  - shadow byte := wdata byte i; written := 1.
  - If rmask and wmask are both set on the same byte of one channel, the read is checked against the pre-write value.
- Misalignment: with ALLOW_MISALIGNED=0, an active channel with a nonzero mask and unaligned mem_addr raises code 2. Its write is still discarded.
- Order tracker (ORDER_CHECK=1):
  - States INIT and RUN; holds next_order.
  - INIT → RUN on the first cycle with any rvfi_valid; next_order := lowest valid order + count of valid channels.
  - Valid channels must occupy channels 0..m-1 with consecutive orders. In RUN, the first of them must equal next_order.
  - Any gap raises code 3.
  - Trapped channels count toward order but not toward memory.
- Error recording:
  - Only the first error is recorded: when err=0 and any error occurs, capture code, order and addr at the clock edge.
  - Among simultaneous errors, the lowest channel wins; within a channel, the lowest byte lane wins.
  - Within a channel, priority is misaligned > mismatch; an order gap is reported only when no memory error exists.
  - Once err=1 the record is frozen; checking and counting continue.
- Assert: with ASSERT_EN=1, assert(!error_now) whenever reset is low.
- Latency: err and err_* appear one cycle after the offending retire.

Decomposition:
- Package rvfi_dmem_pkg: ERR_NONE/ERR_MISMATCH/ERR_MISALIGN/ERR_ORDER constants, and a function computing lane→window-index hit.
- Sub-module rvfi_dmem_lane_map: per channel, takes base_q, mem_addr, masks and produces per-byte hit, word index and lane. Instantiated NRET times.

Test Plan:
- XLEN=32, base 0x1000: store 0xDEADBEEF wmask 0xF at 0x1004, later load rmask 0xF at 0x1004 with rdata 0xDEADBEEF → err=0, read_checks=4.
- Same store, then load rdata 0xDEADBEEE, order 7 → next cycle err=1, code=1, err_order=7, err_addr=0x1004.
- NRET=2, one cycle: ch0 stores 0x55 at byte 0x1008, ch1 loads 0x1008 rdata 0x55 → no error. Swap the channels → ch0's load is unchecked, read_checks unchanged.
- ALLOW_MISALIGNED=1, NWORDS=2: store 0xAABBCCDD at 0x1006 (straddles words 1 and the out-of-window word 2). A load at 0x1004 returns 0xCCDDxxxx → checks 2 bytes, pass. The same store with ALLOW_MISALIGNED=0 → code 2.
- ORDER_CHECK: orders 0,1,3 on successive cycles → err code 3, err_order=3. A trapped instruction with order 2 in between → no error.
- Reset asserted mid-run after writes: a subsequent load with arbitrary rdata → no error, read_checks=0. dmem_base changed after reset release → ignored.

Source files
------------

// File: rtl/rvfi_dmem_pkg.sv
// Shared constants for the windowed RVFI data-memory checker.
// Error codes, order-tracker states and the window hit helper.
package rvfi_dmem_pkg;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_ORDER    = 2'd3;

    typedef enum logic {
        ORD_INIT,
        ORD_RUN
    } ord_state_e;

    // off is (byte address - base) modulo 2^XLEN, zero-extended.
    function automatic logic win_hit(
        input logic [63:0] off,
        input logic [31:0] nbytes
    );
        return off < {32'd0, nbytes};
    endfunction

endpackage

// File: rtl/rvfi_dmem_lane_map.sv
// Maps each byte lane of one retire channel onto the shadow window.
// In: base_q, mem_addr, rmask, wmask. Out: per-byte hit/addr/word/lane, misalign.
module rvfi_dmem_lane_map
    import rvfi_dmem_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int NWORDS           = 4,
    parameter int ALLOW_MISALIGNED = 0,
    localparam int BL  = XLEN / 8,
    localparam int LBL = $clog2(BL),
    localparam int WIW = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic [XLEN-1:0]                base_q,
    input  logic [XLEN-1:0]                mem_addr,
    input  logic [BL-1:0]                  rmask,
    input  logic [BL-1:0]                  wmask,
    output logic                           misalign,
    output logic [BL-1:0]                  hit,
    output logic [BL-1:0][XLEN-1:0]        baddr,
    output logic [BL-1:0][WIW-1:0]         widx,
    output logic [BL-1:0][LBL-1:0]         lane
);

    localparam logic [31:0] WBYTES = 32'(NWORDS * BL);

    logic [BL-1:0][XLEN-1:0] off;

    always_comb begin
        off = '0;
        for (int i = 0; i < BL; i++) begin
            // Address arithmetic wraps at 2^XLEN on purpose.
            baddr[i] = mem_addr + XLEN'(i);
            off[i]   = baddr[i] - base_q;
            hit[i]   = win_hit(64'(off[i]), WBYTES);
            widx[i]  = WIW'(off[i] >> LBL);
            lane[i]  = off[i][LBL-1:0];
        end
        misalign = (ALLOW_MISALIGNED == 0)
                && (|(rmask | wmask))
                && (|mem_addr[LBL-1:0]);
    end

endmodule

// File: rtl/rvfi_dmem_window_check.sv
// Shadows NWORDS words at a captured base and checks RVFI loads against stores.
// In: clk, reset, dmem_base, rvfi_*. Out: sticky err record and read_checks.
module rvfi_dmem_window_check
    import rvfi_dmem_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int NRET             = 1,
    parameter int NWORDS           = 4,
    parameter int ALLOW_MISALIGNED = 0,
    parameter int ORDER_CHECK      = 1,
    parameter int ASSERT_EN        = 1,
    localparam int BL = XLEN / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      dmem_base,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*64-1:0]   rvfi_order,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [NRET*XLEN-1:0] rvfi_mem_addr,
    input  logic [NRET*BL-1:0]   rvfi_mem_rmask,
    input  logic [NRET*BL-1:0]   rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0] rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_mem_wdata,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [63:0]          err_order,
    output logic [XLEN-1:0]      err_addr,
    output logic [31:0]          read_checks
);

    localparam int LBL = $clog2(BL);
    localparam int WIW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [XLEN-1:0] base_q;

    logic [NWORDS-1:0][BL-1:0][7:0] sh_q, sh_n;
    logic [NWORDS-1:0][BL-1:0]      wr_q, wr_n;

    logic [NRET-1:0]                     mis;
    logic [NRET-1:0][BL-1:0]             hit;
    logic [NRET-1:0][BL-1:0][XLEN-1:0]   baddr;
    logic [NRET-1:0][BL-1:0][WIW-1:0]    widx;
    logic [NRET-1:0][BL-1:0][LBL-1:0]    lane;

    logic            mem_err;
    logic [1:0]      mem_code;
    logic [63:0]     mem_ord;
    logic [XLEN-1:0] mem_eaddr;
    logic [31:0]     n_rd;
    logic [32:0]     rc_sum;

    ord_state_e      ord_state, ord_state_n;
    logic [63:0]     next_order, next_order_n;
    logic            ord_err;
    logic [63:0]     ord_ord;
    logic [XLEN-1:0] ord_eaddr;
    logic            first_found;
    logic [63:0]     first_ord;
    logic [63:0]     n_valid;
    logic            prev_v;
    logic [63:0]     prev_ord;
    logic            gap;

    logic            error_now;

    // Base follows dmem_base while reset is held, then freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= dmem_base & ~XLEN'(BL - 1);
        end
    end

    for (genvar k = 0; k < NRET; k++) begin : g_map
        rvfi_dmem_lane_map #(
            .XLEN             (XLEN),
            .NWORDS           (NWORDS),
            .ALLOW_MISALIGNED (ALLOW_MISALIGNED)
        ) u_map (
            .base_q   (base_q),
            .mem_addr (rvfi_mem_addr[k*XLEN +: XLEN]),
            .rmask    (rvfi_mem_rmask[k*BL +: BL]),
            .wmask    (rvfi_mem_wmask[k*BL +: BL]),
            .misalign (mis[k]),
            .hit      (hit[k]),
            .baddr    (baddr[k]),
            .widx     (widx[k]),
            .lane     (lane[k])
        );
    end

    // Channels chain through sh_n/wr_n so an earlier store feeds a later load.
    always_comb begin
        sh_n      = sh_q;
        wr_n      = wr_q;
        mem_err   = 1'b0;
        mem_code  = ERR_NONE;
        mem_ord   = '0;
        mem_eaddr = '0;
        n_rd      = '0;
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k] && !rvfi_trap[k]) begin
                if (mis[k]) begin
                    if (!mem_err) begin
                        mem_err   = 1'b1;
                        mem_code  = ERR_MISALIGN;
                        mem_ord   = rvfi_order[k*64 +: 64];
                        mem_eaddr = rvfi_mem_addr[k*XLEN +: XLEN];
                    end
                end else begin
                    // Reads first so a read-modify-write sees the old byte.
                    for (int i = 0; i < BL; i++) begin
                        if (rvfi_mem_rmask[k*BL + i] && hit[k][i]
                            && wr_n[widx[k][i]][lane[k][i]]) begin
                            n_rd = n_rd + 32'd1;
                            if (!mem_err && rvfi_mem_rdata[k*XLEN + i*8 +: 8]
                                != sh_n[widx[k][i]][lane[k][i]]) begin
                                mem_err   = 1'b1;
                                mem_code  = ERR_MISMATCH;
                                mem_ord   = rvfi_order[k*64 +: 64];
                                mem_eaddr = baddr[k][i];
                            end
                        end
                    end
                    for (int i = 0; i < BL; i++) begin
                        if (rvfi_mem_wmask[k*BL + i] && hit[k][i]) begin
                            sh_n[widx[k][i]][lane[k][i]] =
                                rvfi_mem_wdata[k*XLEN + i*8 +: 8];
                            wr_n[widx[k][i]][lane[k][i]] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ord_state  <= ORD_INIT;
            next_order <= '0;
        end else begin
            ord_state  <= ord_state_n;
            next_order <= next_order_n;
        end
    end

    // Valid channels must be packed from 0 with consecutive orders.
    always_comb begin
        ord_state_n  = ord_state;
        next_order_n = next_order;
        ord_err      = 1'b0;
        ord_ord      = '0;
        ord_eaddr    = '0;
        first_found  = 1'b0;
        first_ord    = '0;
        n_valid      = '0;
        prev_v       = 1'b1;
        prev_ord     = '0;
        gap          = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k]) begin
                n_valid = n_valid + 64'd1;
                if (!first_found) begin
                    first_found = 1'b1;
                    first_ord   = rvfi_order[k*64 +: 64];
                end
                if (k == 0) begin
                    gap = (ord_state == ORD_RUN)
                       && (rvfi_order[63:0] != next_order);
                end else begin
                    gap = !prev_v
                       || (rvfi_order[k*64 +: 64] != prev_ord + 64'd1);
                end
                if (gap && !ord_err && (ORDER_CHECK != 0)) begin
                    ord_err   = 1'b1;
                    ord_ord   = rvfi_order[k*64 +: 64];
                    ord_eaddr = rvfi_mem_addr[k*XLEN +: XLEN];
                end
            end
            prev_v   = rvfi_valid[k];
            prev_ord = rvfi_order[k*64 +: 64];
        end
        if (first_found) begin
            ord_state_n  = ORD_RUN;
            next_order_n = first_ord + n_valid;
        end
    end

    assign error_now = mem_err || ord_err;
    assign rc_sum    = {1'b0, read_checks} + {1'b0, n_rd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q        <= '0;
            wr_q        <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            err_order   <= '0;
            err_addr    <= '0;
            read_checks <= '0;
        end else begin
            sh_q        <= sh_n;
            wr_q        <= wr_n;
            read_checks <= rc_sum[32] ? '1 : rc_sum[31:0];
            // Memory errors outrank order gaps; first error freezes the record.
            if (!err && error_now) begin
                err       <= 1'b1;
                err_code  <= mem_err ? mem_code : ERR_ORDER;
                err_order <= mem_err ? mem_ord : ord_ord;
                err_addr  <= mem_err ? mem_eaddr : ord_eaddr;
            end
        end
    end

    if (ASSERT_EN != 0) begin : g_assert
        always @(posedge clk) begin
            if (!reset) begin
                assert (!error_now);
            end
        end
    end

endmodule

// File: tb/tb_rvfi_dmem_window_check.sv
// Scoreboard bench for rvfi_dmem_window_check.
// Instance A: NRET=2 aligned; instance B: NRET=1 misaligned, NWORDS=2.
module tb_rvfi_dmem_window_check;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [63:0] ord;
        logic [31:0] addr;
        logic [31:0] rc;
    } res_t;

    typedef struct {
        string name;
        res_t  r;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]  base_a, base_b;
    logic [1:0]   va, ta;
    logic [127:0] oa;
    logic [63:0]  aa, rda, wda;
    logic [7:0]   rma, wma;
    logic         err_a;
    logic [1:0]   code_a;
    logic [63:0]  eord_a;
    logic [31:0]  eaddr_a, rc_a;

    logic         vb, tb_t;
    logic [63:0]  ob;
    logic [31:0]  ab, rdb, wdb;
    logic [3:0]   rmb, wmb;
    logic         err_b;
    logic [1:0]   code_b;
    logic [63:0]  eord_b;
    logic [31:0]  eaddr_b, rc_b;

    rvfi_dmem_window_check #(
        .XLEN(32), .NRET(2), .NWORDS(4), .ALLOW_MISALIGNED(0),
        .ORDER_CHECK(1), .ASSERT_EN(0)
    ) u_a (
        .clk(clk), .reset(reset), .dmem_base(base_a),
        .rvfi_valid(va), .rvfi_order(oa), .rvfi_trap(ta),
        .rvfi_mem_addr(aa), .rvfi_mem_rmask(rma), .rvfi_mem_wmask(wma),
        .rvfi_mem_rdata(rda), .rvfi_mem_wdata(wda),
        .err(err_a), .err_code(code_a), .err_order(eord_a),
        .err_addr(eaddr_a), .read_checks(rc_a)
    );

    rvfi_dmem_window_check #(
        .XLEN(32), .NRET(1), .NWORDS(2), .ALLOW_MISALIGNED(1),
        .ORDER_CHECK(0), .ASSERT_EN(0)
    ) u_b (
        .clk(clk), .reset(reset), .dmem_base(base_b),
        .rvfi_valid(vb), .rvfi_order(ob), .rvfi_trap(tb_t),
        .rvfi_mem_addr(ab), .rvfi_mem_rmask(rmb), .rvfi_mem_wmask(wmb),
        .rvfi_mem_rdata(rdb), .rvfi_mem_wdata(wdb),
        .err(err_b), .err_code(code_b), .err_order(eord_b),
        .err_addr(eaddr_b), .read_checks(rc_b)
    );

    function automatic res_t obs_a();
        return '{err: err_a, code: code_a, ord: eord_a,
                 addr: eaddr_a, rc: rc_a};
    endfunction

    function automatic res_t obs_b();
        return '{err: err_b, code: code_b, ord: eord_b,
                 addr: eaddr_b, rc: rc_b};
    endfunction

    task automatic clr();
        va = '0; ta = '0; oa = '0; aa = '0;
        rma = '0; wma = '0; rda = '0; wda = '0;
        vb = 1'b0; tb_t = 1'b0; ob = '0; ab = '0;
        rmb = '0; wmb = '0; rdb = '0; wdb = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic push(input string n, input logic e, input logic [1:0] c,
                        input logic [63:0] o, input logic [31:0] a,
                        input logic [31:0] r);
        exp_t x;
        x.name = n;
        x.r = '{err: e, code: c, ord: o, addr: a, rc: r};
        sb.push_back(x);
    endtask

    task automatic drv_a(input int ch, input logic [63:0] o,
                         input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] rd,
                         input logic [31:0] wd, input logic tr);
        va[ch] = 1'b1;
        ta[ch] = tr;
        oa[ch*64 +: 64] = o;
        aa[ch*32 +: 32] = a;
        rma[ch*4 +: 4] = rm;
        wma[ch*4 +: 4] = wm;
        rda[ch*32 +: 32] = rd;
        wda[ch*32 +: 32] = wd;
    endtask

    task automatic drv_b(input logic [63:0] o, input logic [31:0] a,
                         input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] rd, input logic [31:0] wd);
        vb = 1'b1; ob = o; ab = a;
        rmb = rm; wmb = wm; rdb = rd; wdb = wd;
    endtask

    task automatic do_reset(input logic [31:0] ba, input logic [31:0] bb);
        clr();
        base_a = ba;
        base_b = bb;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t x; res_t o;
        do_reset(32'h1003, 32'h1000);
        push("reset_a", 0, 0, 0, 0, 0);
        x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        push("reset_b", 0, 0, 0, 0, 0);
        x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_match();
        exp_t x; res_t o;
        do_reset(32'h1003, 32'h1000);
        drv_a(0, 0, 32'h1004, 4'h0, 4'hf, 0, 32'hdeadbeef, 0);
        push("match_store", 0, 0, 0, 0, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 1, 32'h1004, 4'hf, 4'h0, 32'hdeadbeef, 0, 0);
        push("match_load", 0, 0, 0, 0, 4);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_mismatch();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 6, 32'h1004, 4'h0, 4'hf, 0, 32'hdeadbeef, 0);
        push("mm_store", 0, 0, 0, 0, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 7, 32'h1004, 4'hf, 4'h0, 32'hdeadbeee, 0, 0);
        push("mm_load", 1, 1, 7, 32'h1004, 4);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 8, 32'h1004, 4'hf, 4'h0, 32'h0, 0, 0);
        push("mm_frozen", 1, 1, 7, 32'h1004, 8);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_same_cycle();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 0, 32'h1008, 4'h0, 4'h1, 0, 32'h55, 0);
        drv_a(1, 1, 32'h1008, 4'h1, 4'h0, 32'h55, 0, 0);
        push("sc_fwd", 0, 0, 0, 0, 1);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 0, 32'h1008, 4'h1, 4'h0, 32'h99, 0, 0);
        drv_a(1, 1, 32'h1008, 4'h0, 4'h1, 0, 32'h55, 0);
        push("sc_swap", 0, 0, 0, 0, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 2, 32'h1008, 4'h1, 4'h0, 32'h55, 0, 0);
        push("sc_after", 0, 0, 0, 0, 1);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 3, 32'h1008, 4'h1, 4'h1, 32'h55, 32'h66, 0);
        push("sc_rmw", 0, 0, 0, 0, 2);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 4, 32'h1008, 4'h1, 4'h0, 32'h66, 0, 0);
        push("sc_rmw_new", 0, 0, 0, 0, 3);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_misalign();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 0, 32'h1006, 4'h0, 4'hf, 0, 32'haabbccdd, 0);
        push("mis_store", 1, 2, 0, 32'h1006, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 1, 32'h1004, 4'hf, 4'h0, 32'haabbccdd, 0, 0);
        push("mis_discard", 1, 2, 0, 32'h1006, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_order();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            drv_a(0, (i == 2) ? 64'd3 : 64'(i), 32'h40, 0, 0, 0, 0, 0);
            if (i == 2) push("ord_gap", 1, 3, 3, 32'h40, 0);
            else        push("ord_ok", 0, 0, 0, 0, 0);
            tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
            if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        end
        do_reset(32'h1000, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drv_a(0, 2, 32'h1000, 0, 4'hf, 0, 32'hff, 1);
            else if (i == 3) drv_a(0, 3, 32'h1000, 4'hf, 0, 32'h0, 0, 0);
            else drv_a(0, 64'(i), 32'h40, 0, 0, 0, 0, 0);
            tick();
        end
        push("ord_trap", 0, 0, 0, 0, 0);
        x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        do_reset(32'h1000, 32'h1000);
        drv_a(1, 5, 32'h2222, 0, 0, 0, 0, 0);
        push("ord_hole", 1, 3, 5, 32'h2222, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 0, 32'h10, 0, 0, 0, 0, 0);
        drv_a(1, 2, 32'h20, 0, 0, 0, 0, 0);
        push("ord_skip", 1, 3, 2, 32'h20, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 0, 32'h1004, 0, 4'hf, 0, 32'h01020304, 0);
        tick();
        drv_a(0, 5, 32'h1004, 4'hf, 0, 32'h01020300, 0, 0);
        push("ord_prio", 1, 1, 5, 32'h1004, 4);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_reset_mid();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'h1000);
        drv_a(0, 0, 32'h1004, 0, 4'hf, 0, 32'hdeadbeef, 0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        base_a = 32'h2000;
        drv_a(0, 0, 32'h1004, 4'hf, 0, 32'h12345678, 0, 0);
        push("rst_unwritten", 0, 0, 0, 0, 0);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_a(0, 1, 32'h1004, 0, 4'hf, 0, 32'hcafef00d, 0);
        tick();
        drv_a(0, 2, 32'h1004, 4'hf, 0, 32'hcafef00d, 0, 0);
        push("rst_base_held", 0, 0, 0, 0, 4);
        tick(); x = sb.pop_front(); o = obs_a(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_straddle();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'h1000);
        drv_b(10, 32'h1006, 0, 4'hf, 0, 32'haabbccdd);
        push("str_store", 0, 0, 0, 0, 0);
        tick(); x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_b(20, 32'h1004, 4'hf, 0, 32'hccdd1234, 0);
        push("str_load", 0, 0, 0, 0, 2);
        tick(); x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_b(30, 32'h1008, 4'hf, 0, 32'h0, 0);
        push("str_outside", 0, 0, 0, 0, 2);
        tick(); x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_b(40, 32'h1006, 4'hf, 0, 32'h000000dd, 0);
        push("str_mismatch", 1, 1, 40, 32'h1007, 4);
        tick(); x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    task automatic test_wrap();
        exp_t x; res_t o;
        do_reset(32'h1000, 32'hfffffffd);
        drv_b(0, 32'hfffffffe, 0, 4'hf, 0, 32'h11223344);
        tick();
        drv_b(1, 32'h0, 4'h3, 0, 32'h00001122, 0);
        push("wrap_low", 0, 0, 0, 0, 2);
        tick(); x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
        drv_b(2, 32'hfffffffc, 4'hc, 0, 32'h33440000, 0);
        push("wrap_high", 0, 0, 0, 0, 4);
        tick(); x = sb.pop_front(); o = obs_b(); n_chk++;
        if (o !== x.r) begin n_err++; $display("FAIL %s: got %p want %p", x.name, o, x.r); end
    endtask

    initial begin
        clr();
        base_a = 32'h1000;
        base_b = 32'h1000;
        test_reset();
        test_match();
        test_mismatch();
        test_same_cycle();
        test_misalign();
        test_order();
        test_reset_mid();
        test_straddle();
        test_wrap();
        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
